mips_run_ctrl: RTL and testbench
================================

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, width of ALU result and signature.
REQ-002 SHALL have parameters: ADDR_W, default 16, width of PC.
REQ-003 SHALL have parameters: RST_CYCLES, default 5, number of cycles the CPU reset is held after start; 1 to 255.
REQ-004 SHALL have parameters: MAX_CYCLES, default 1024, run-cycle budget before timeout.
REQ-005 SHALL have parameters: STALL_LIMIT, default 4, consecutive unchanged-PC comparisons that declare halt; 1 to 15.
REQ-006 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have ports: reset  in  1  asynchronous, active-low block reset.
REQ-008 SHALL have ports: start  in  1  one-cycle request to (re)run the CPU.
REQ-009 SHALL have ports: pc_in  in  ADDR_W  CPU pc_out.
REQ-010 SHALL have ports: alu_in  in  DATA_W  CPU alu_result.
REQ-011 SHALL have ports: cpu_reset  out  1  active-high reset driven to the CPU.
REQ-012 SHALL have ports: running  out  1  high in RUN.
REQ-013 SHALL have ports: done  out  1  high in DONE.
REQ-014 SHALL have ports: timeout  out  1  run ended by cycle budget.
REQ-015 SHALL have ports: cycle_count  out  $clog2(MAX_CYCLES+1)  RUN cycles elapsed.
REQ-016 SHALL have ports: signature  out  DATA_W  ALU trace signature.
REQ-017 SHALL have ports: last_pc  out  ADDR_W  PC registered in the last RUN cycle.

Function
REQ-018 SHALL implement FSM with states IDLE, HOLD, RUN and DONE, all outputs registered.
REQ-019 IDLE SHALL behave as: cpu_reset=1; start -> HOLD next cycle; all counters, flags and signature cleared on that transition.
REQ-020 HOLD SHALL behave as: cpu_reset=1 for exactly RST_CYCLES cycles, then -> RUN; start ignored.
REQ-021 RUN SHALL behave as: cpu_reset=0, running=1; cycle_count +1 per cycle; last_pc <= pc_in each cycle; start ignored.
REQ-022 In RUN, halt detection SHALL work as: from the second RUN cycle, pc_in==last_pc increments stall counter, else clears it; counter reaching STALL_LIMIT -> DONE next cycle, timeout=0.
REQ-023 In RUN, timeout SHALL work as: cycle_count reaching MAX_CYCLES -> DONE next cycle, timeout=1; cycle_count saturates, never wraps.
REQ-024 If halt and budget coincide in the same cycle, halt SHALL win: timeout=0.
REQ-025 DONE SHALL behave as: done=1, cpu_reset=1 (CPU frozen), cycle_count/signature/last_pc held; start -> HOLD with full clear (restart).
REQ-026 cpu_reset SHALL never be low outside RUN.

Reset
REQ-027 On reset low, the block SHALL immediately (asynchronously) enter IDLE: cpu_reset=1, running=0, done=0, timeout=0, cycle_count=0, signature=0, last_pc=0, internal counters=0.
REQ-028 Reset asserted mid-RUN SHALL abort the run; no done pulse SHALL be produced.
REQ-029 Release of reset SHALL be synchronous-safe: the first active edge after release leaves the block in IDLE.

Configuration
REQ-030 Macro MIPS_RUN_SIG_EN defined: each RUN cycle SHALL update signature <= rotl1(signature) XOR alu_in.
REQ-031 Macro MIPS_RUN_SIG_EN undefined: signature SHALL be constant 0 and no signature register SHALL be synthesised.

Verification
REQ-032 Bench SHALL cover hold length: RST_CYCLES=5, start pulse at edge 0 -> cpu_reset=1 through edge 6, 0 from edge 7, running=1 from edge 7.
REQ-033 Bench SHALL cover halt: STALL_LIMIT=4, pc_in increments 0,2,4,6 then held at 0x000A -> done=1, timeout=0, last_pc=0x000A, cpu_reset=1 one cycle after 4th equal compare.
REQ-034 Bench SHALL cover timeout: MAX_CYCLES=20, pc_in always incrementing -> done=1, timeout=1, cycle_count=20 and held.
REQ-035 Bench SHALL cover signature (macro defined): alu_in 0x0001 then 0x0002 in the first two RUN cycles -> signature 0x0001 then 0x0000; macro undefined -> 0x0000 throughout.
REQ-036 Bench SHALL cover reset mid-run: reset low at cycle 10 of RUN -> same instant all outputs at REQ-027 values; after release, start re-runs normally with cycle_count from 0.
REQ-037 Bench SHALL cover restart and ignore: start in RUN -> no effect; start in DONE -> HOLD, done=0, timeout=0, signature=0 next cycle.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences reset, run and halt of a MIPS core and collects run statistics.
// Build option: define MIPS_RUN_SIG_EN to keep the ALU-trace signature register.
module mips_run_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RST_CYCLES  = 5,
    parameter int unsigned MAX_CYCLES  = 1024,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               pc_in,
    input  logic [DATA_W-1:0]               alu_in,
    output logic                            cpu_reset,
    output logic                            running,
    output logic                            done,
    output logic                            timeout,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycle_count,
    output logic [DATA_W-1:0]               signature,
    output logic [ADDR_W-1:0]               last_pc
);

    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYCLES);
    localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES);
    localparam logic [3:0]       STALL_MAX = 4'(STALL_LIMIT);

    typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [7:0]         r_hold_cnt, w_hold_cnt_d;
    logic [3:0]         r_stall_cnt, w_stall_cnt_d;
    logic [CNT_W-1:0]   r_cycle_count, w_cycle_count_d;
    logic [ADDR_W-1:0]  r_last_pc, w_last_pc_d;
    logic               r_timeout, w_timeout_d;
    logic               r_cpu_reset, r_running, r_done;
    logic               w_start_ack, w_halt, w_budget;

    assign w_start_ack = start && ((r_state == StIdle) || (r_state == StDone));

    always_comb begin
        w_state_d       = r_state;
        w_hold_cnt_d    = r_hold_cnt;
        w_stall_cnt_d   = r_stall_cnt;
        w_cycle_count_d = r_cycle_count;
        w_last_pc_d     = r_last_pc;
        w_timeout_d     = r_timeout;
        w_halt          = 1'b0;
        w_budget        = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_start_ack) begin
                    w_state_d       = StHold;
                    w_hold_cnt_d    = '0;
                    w_stall_cnt_d   = '0;
                    w_cycle_count_d = '0;
                    w_last_pc_d     = '0;
                    w_timeout_d     = 1'b0;
                end
            end
            StHold: begin
                // The start-acknowledge cycle is followed by RST_CYCLES counted hold cycles.
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_d = StRun;
                end else begin
                    w_hold_cnt_d = r_hold_cnt + 8'd1;
                end
            end
            StRun: begin
                w_cycle_count_d = (r_cycle_count == CNT_MAX) ? r_cycle_count
                                                             : r_cycle_count + CNT_W'(1);
                w_last_pc_d     = pc_in;
                // A zero count marks the first RUN cycle, which has no previous PC.
                if (r_cycle_count != '0) begin
                    w_stall_cnt_d = (pc_in == r_last_pc) ? r_stall_cnt + 4'd1 : 4'd0;
                end
                w_halt   = (w_stall_cnt_d == STALL_MAX);
                w_budget = (w_cycle_count_d == CNT_MAX);
                if (w_halt || w_budget) begin
                    w_state_d   = StDone;
                    w_timeout_d = !w_halt;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_hold_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_cycle_count <= '0;
            r_last_pc     <= '0;
            r_timeout     <= 1'b0;
            r_cpu_reset   <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_stall_cnt   <= w_stall_cnt_d;
            r_cycle_count <= w_cycle_count_d;
            r_last_pc     <= w_last_pc_d;
            r_timeout     <= w_timeout_d;
            r_cpu_reset   <= (w_state_d != StRun);
            r_running     <= (w_state_d == StRun);
            r_done        <= (w_state_d == StDone);
        end
    end

`ifdef MIPS_RUN_SIG_EN
    logic [DATA_W-1:0] r_signature, w_signature_d;

    always_comb begin
        w_signature_d = r_signature;
        if (w_start_ack) begin
            w_signature_d = '0;
        end else if (r_state == StRun) begin
            w_signature_d = {r_signature[DATA_W-2:0], r_signature[DATA_W-1]} ^ alu_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_signature <= '0;
        end else begin
            r_signature <= w_signature_d;
        end
    end

    assign signature = r_signature;
`else
    logic w_unused_alu;
    assign w_unused_alu = ^alu_in;
    assign signature    = '0;
`endif

    assign cpu_reset   = r_cpu_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign last_pc     = r_last_pc;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus randomized PC traces
// checked against a window-based halt/timeout reference model.
module tb_mips_run_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int RSTC  = 5;
    localparam int MAXC  = 20;
    localparam int STALL = 4;
    localparam int CW    = $clog2(MAXC + 1);
`ifdef MIPS_RUN_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] pc_in;
    logic [DW-1:0] alu_in;
    logic          cpu_reset, running, done, timeout;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] signature;
    logic [AW-1:0] last_pc;

    logic [AW-1:0] q_pc  [32];
    logic [DW-1:0] q_alu [32];

    int n_checks = 0;
    int n_errors = 0;

    mips_run_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .RST_CYCLES (RSTC),
        .MAX_CYCLES (MAXC),
        .STALL_LIMIT(STALL)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc_in      (pc_in),
        .alu_in     (alu_in),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .signature  (signature),
        .last_pc    (last_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds q_pc/q_alu one entry per RUN cycle until done, within a cycle budget.
    task automatic run_prog(output int seen, output bit got_done);
        int guard = 0;
        while (running !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        seen = 0;
        while (done !== 1'b1 && seen < MAXC + 4) begin
            pc_in  = q_pc[seen];
            alu_in = q_alu[seen];
            tick();
            seen++;
        end
        got_done = (done === 1'b1);
    endtask

    // Halt is the first RUN cycle closing a window of STALL+1 equal PCs; budget otherwise.
    function automatic int model_end(output bit to);
        int halt_k = 0;
        for (int k = STALL + 1; k <= MAXC; k++) begin
            bit same = 1'b1;
            for (int j = k - STALL; j < k; j++) begin
                if (q_pc[j] != q_pc[j-1]) same = 1'b0;
            end
            if (same) begin
                halt_k = k;
                break;
            end
        end
        to = (halt_k == 0);
        return (halt_k == 0) ? MAXC : halt_k;
    endfunction

    function automatic logic [DW-1:0] model_sig(input int n);
        logic [DW-1:0] s = '0;
        if (!SIG_EN) return '0;
        for (int i = 0; i < n; i++) s = {s[DW-2:0], s[DW-1]} ^ q_alu[i];
        return s;
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        pc_in  = '0;
        alu_in = '0;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: cpu_reset=%b running=%b done=%b timeout=%b, required 1000",
                     cpu_reset, running, done, timeout);
        end
        n_checks++;
        if (cycle_count !== '0 || signature !== '0 || last_pc !== '0) begin
            n_errors++;
            $display("FAIL reset_values: count=%0d sig=%h last_pc=%h, required 0/0/0",
                     cycle_count, signature, last_pc);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: cpu_reset=%b running=%b done=%b, required 100",
                     cpu_reset, running, done);
        end
    endtask

    task automatic test_hold();
        start_pulse();
        for (int e = 1; e <= 6; e++) begin
            n_checks++;
            if (cpu_reset !== 1'b1 || running !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_edge%0d: cpu_reset=%b running=%b, required 1/0",
                         e, cpu_reset, running);
            end
            if (e < 6) tick();
        end
        tick();
        n_checks++;
        if (cpu_reset !== 1'b0 || running !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_edge7: cpu_reset=%b running=%b, required 0/1", cpu_reset, running);
        end
        apply_reset();
    endtask

    task automatic test_signature();
        logic [DW-1:0] exp1;
        int guard = 0;
        exp1 = SIG_EN ? 16'h0001 : 16'h0000;
        start_pulse();
        while (running !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        pc_in  = 16'h0100;
        alu_in = 16'h0001;
        tick();
        n_checks++;
        if (signature !== exp1) begin
            n_errors++;
            $display("FAIL sig_cycle1: got %h, required %h", signature, exp1);
        end
        pc_in  = 16'h0104;
        alu_in = 16'h0002;
        tick();
        n_checks++;
        if (signature !== 16'h0000) begin
            n_errors++;
            $display("FAIL sig_cycle2: got %h, required 0000", signature);
        end
        apply_reset();
    endtask

    task automatic test_halt();
        int  seen;
        bit  got;
        logic [DW-1:0] exp_sig;
        for (int i = 0; i < 32; i++) begin
            q_pc[i]  = (i < 4) ? AW'(2 * i) : 16'h000A;
            q_alu[i] = DW'(i + 1);
        end
        exp_sig = model_sig(9);
        start_pulse();
        run_prog(seen, got);
        n_checks++;
        if (!got || seen != 9) begin
            n_errors++;
            $display("FAIL halt_cycle: done=%b after %0d cycles, required done after 9", got, seen);
        end
        n_checks++;
        if (timeout !== 1'b0 || cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_flags: timeout=%b cpu_reset=%b running=%b, required 0/1/0",
                     timeout, cpu_reset, running);
        end
        n_checks++;
        if (last_pc !== 16'h000A || cycle_count !== CW'(9)) begin
            n_errors++;
            $display("FAIL halt_values: last_pc=%h count=%0d, required 000a/9", last_pc, cycle_count);
        end
        pc_in  = 16'h1234;
        alu_in = 16'hFFFF;
        repeat (3) tick();
        n_checks++;
        if (done !== 1'b1 || cycle_count !== CW'(9) || last_pc !== 16'h000A
            || signature !== exp_sig) begin
            n_errors++;
            $display("FAIL halt_hold: done=%b count=%0d last_pc=%h sig=%h, required 1/9/000a/%h",
                     done, cycle_count, last_pc, signature, exp_sig);
        end
    endtask

    task automatic test_timeout();
        int  seen;
        bit  got;
        logic [DW-1:0] exp_sig;
        for (int i = 0; i < 32; i++) begin
            q_pc[i]  = AW'(2 * i);
            q_alu[i] = DW'($urandom);
        end
        exp_sig = model_sig(MAXC);
        start_pulse();
        run_prog(seen, got);
        n_checks++;
        if (!got || seen != MAXC || timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_end: done=%b cycles=%0d timeout=%b, required 1/%0d/1",
                     got, seen, timeout, MAXC);
        end
        n_checks++;
        if (cycle_count !== CW'(MAXC) || last_pc !== AW'(2 * (MAXC - 1)) || signature !== exp_sig) begin
            n_errors++;
            $display("FAIL timeout_values: count=%0d last_pc=%h sig=%h, required %0d/%h/%h",
                     cycle_count, last_pc, signature, MAXC, AW'(2 * (MAXC - 1)), exp_sig);
        end
        repeat (4) tick();
        n_checks++;
        if (cycle_count !== CW'(MAXC) || done !== 1'b1 || timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_hold: count=%0d done=%b timeout=%b, required %0d/1/1",
                     cycle_count, done, timeout, MAXC);
        end
    endtask

    // Entered from DONE with timeout=1 left by test_timeout.
    task automatic test_restart();
        start_pulse();
        n_checks++;
        if (done !== 1'b0 || timeout !== 1'b0 || signature !== '0 || cycle_count !== '0
            || last_pc !== '0 || cpu_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_clear: done=%b timeout=%b sig=%h count=%0d last_pc=%h rst=%b",
                     done, timeout, signature, cycle_count, last_pc, cpu_reset);
        end
        apply_reset();
    endtask

    task automatic test_ignore();
        int seen = 0;
        int guard = 0;
        for (int i = 0; i < 32; i++) begin
            q_pc[i]  = (i < 4) ? AW'(2 * i) : 16'h000A;
            q_alu[i] = DW'(i);
        end
        start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (running !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard != 5) begin
            n_errors++;
            $display("FAIL ignore_hold_start: RUN after %0d more edges, required 5", guard);
        end
        while (done !== 1'b1 && seen < MAXC + 4) begin
            start  = (seen == 3 || seen == 5);
            pc_in  = q_pc[seen];
            alu_in = q_alu[seen];
            tick();
            start = 1'b0;
            seen++;
            if (seen == 4) begin
                n_checks++;
                if (running !== 1'b1 || cpu_reset !== 1'b0 || cycle_count !== CW'(4)) begin
                    n_errors++;
                    $display("FAIL ignore_run_start: running=%b rst=%b count=%0d, required 1/0/4",
                             running, cpu_reset, cycle_count);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || seen != 9 || timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_halt: done=%b cycles=%0d timeout=%b, required 1/9/0",
                     done, seen, timeout);
        end
    endtask

    task automatic test_coincide();
        int seen;
        bit got;
        for (int i = 0; i < 32; i++) begin
            q_pc[i]  = (i < 15) ? AW'(2 * i) : 16'h0100;
            q_alu[i] = DW'($urandom);
        end
        start_pulse();
        run_prog(seen, got);
        n_checks++;
        if (!got || seen != MAXC || timeout !== 1'b0 || cycle_count !== CW'(MAXC)) begin
            n_errors++;
            $display("FAIL coincide: done=%b cycles=%0d timeout=%b count=%0d, required 1/%0d/0/%0d",
                     got, seen, timeout, cycle_count, MAXC, MAXC);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        start_pulse();
        while (running !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 9; i++) begin
            pc_in  = AW'(2 * i);
            alu_in = DW'($urandom);
            tick();
        end
        pc_in = 16'h0012;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0
            || cycle_count !== '0 || signature !== '0 || last_pc !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset: rst=%b run=%b done=%b to=%b count=%0d sig=%h pc=%h",
                     cpu_reset, running, done, timeout, cycle_count, signature, last_pc);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_release: done=%b cpu_reset=%b running=%b, required 0/1/0",
                     done, cpu_reset, running);
        end
        start_pulse();
        guard = 0;
        while (running !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (running !== 1'b1 || cycle_count !== '0) begin
            n_errors++;
            $display("FAIL midrun_rerun_start: running=%b count=%0d, required 1/0",
                     running, cycle_count);
        end
        pc_in = 16'h0040;
        tick();
        n_checks++;
        if (cycle_count !== CW'(1) || last_pc !== 16'h0040) begin
            n_errors++;
            $display("FAIL midrun_rerun_cycle1: count=%0d last_pc=%h, required 1/0040",
                     cycle_count, last_pc);
        end
        apply_reset();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int  seen, exp_end;
            bit  got, exp_to;
            int  stay_pct;
            logic [DW-1:0] exp_sig;
            stay_pct = 20 + it * 10;
            for (int i = 0; i < 32; i++) begin
                if (i > 0 && $urandom_range(0, 99) < stay_pct) q_pc[i] = q_pc[i-1];
                else q_pc[i] = AW'($urandom_range(0, 3) * 2);
                q_alu[i] = DW'($urandom);
            end
            exp_end = model_end(exp_to);
            exp_sig = model_sig(exp_end);
            start_pulse();
            run_prog(seen, got);
            n_checks++;
            if (!got || seen != exp_end || timeout !== exp_to) begin
                n_errors++;
                $display("FAIL rand%0d_end: done=%b cycles=%0d timeout=%b, required 1/%0d/%b",
                         it, got, seen, timeout, exp_end, exp_to);
            end
            n_checks++;
            if (cycle_count !== CW'(exp_end) || last_pc !== q_pc[exp_end-1]
                || signature !== exp_sig) begin
                n_errors++;
                $display("FAIL rand%0d_values: count=%0d last_pc=%h sig=%h, required %0d/%h/%h",
                         it, cycle_count, last_pc, signature, exp_end, q_pc[exp_end-1], exp_sig);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_signature();
        test_halt();
        test_timeout();
        test_restart();
        test_ignore();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
